sram_owner_sequencer: RTL and testbench

//  Top-level decode sequencer and SRAM ownership arbiter. Replaces the top-level FSM and SRAM muxes.

---
 rtl/sram_owner_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_sram_owner_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_owner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_owner_sequencer
//  Description : Top-level decode sequencer and single-port SRAM ownership
//                arbiter. Walks idle/VGA -> UART receive -> Milestone2 ->
//                Milestone1 -> idle. Inserts a one-cycle ownerless gap before
//                each milestone and guards each milestone with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_owner_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int UART_TMO = 50000000,
    parameter int MS_TMO   = 33554431,
    parameter int TMR_W    = 26
) (
    input  logic              CLOCK_50_I,
    input  logic              Resetn,
    input  logic              UART_RX_I,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    input  logic              uart_we_n,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic              m2_we_n,
    input  logic              m2_stop,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we_n,
    input  logic              m1_stop,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic              UART_rx_initialize,
    output logic              UART_rx_enable,
    output logic              VGA_enable,
    output logic              M2_start,
    output logic              M1_start,
    output logic [2:0]        state_o,
    output logic              abort_err,
    output logic [7:0]        decode_cnt
);

    // State encoding is visible on state_o, so the values are fixed.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UART = 3'd1;
    localparam logic [2:0] S_GAP2 = 3'd2;
    localparam logic [2:0] S_M2   = 3'd3;
    localparam logic [2:0] S_GAP1 = 3'd4;
    localparam logic [2:0] S_M1   = 3'd5;

    // Terminal timer values: UART ends on the last idle cycle, milestones
    // abort once the timer has reached the watchdog limit.
    localparam logic [TMR_W-1:0] c_uart_last = TMR_W'(UART_TMO - 1);
    localparam logic [TMR_W-1:0] c_ms_last   = TMR_W'(MS_TMO);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             abort_q, abort_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rx_init_q, rx_init_d;
    logic             rx_en_q;

    // State register.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shared timer, sticky abort flag, decode counter and UART rx pulses.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            timer_q   <= '0;
            abort_q   <= 1'b0;
            cnt_q     <= 8'd0;
            rx_init_q <= 1'b0;
            rx_en_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            rx_init_q <= rx_init_d;
            rx_en_q   <= rx_init_q;
        end
    end

    // Next-state logic; stop requests take priority over the watchdog.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        rx_init_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!UART_RX_I) begin
                    state_d   = S_UART;
                    rx_init_d = 1'b1;
                end
            end
            S_UART: begin
                if (!uart_we_n) begin
                    timer_d = '0;
                end else if (timer_q == c_uart_last) begin
                    state_d = S_GAP2;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP2: begin
                state_d = S_M2;
                timer_d = '0;
            end
            S_M2: begin
                if (m2_stop) begin
                    state_d = S_GAP1;
                    timer_d = '0;
                end else if (timer_q == c_ms_last) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP1: begin
                state_d = S_M1;
                timer_d = '0;
            end
            S_M1: begin
                if (m1_stop) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 8'd1;
                    timer_d = '0;
                end else if (timer_q == c_ms_last) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output logic: SRAM mux driven straight from the registered state.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        VGA_enable      = 1'b0;
        M2_start        = 1'b0;
        M1_start        = 1'b0;
        case (state_q)
            S_IDLE: begin
                SRAM_address = vga_addr;
                VGA_enable   = 1'b1;
            end
            S_UART: begin
                SRAM_address    = uart_addr;
                SRAM_write_data = uart_wdata;
                SRAM_we_n       = uart_we_n;
            end
            S_M2: begin
                SRAM_address    = m2_addr;
                SRAM_write_data = m2_wdata;
                SRAM_we_n       = m2_we_n;
                M2_start        = 1'b1;
            end
            S_M1: begin
                SRAM_address    = m1_addr;
                SRAM_write_data = m1_wdata;
                SRAM_we_n       = m1_we_n;
                M1_start        = 1'b1;
            end
            default: begin
                SRAM_we_n = 1'b1;
            end
        endcase
    end

    assign UART_rx_initialize = rx_init_q;
    assign UART_rx_enable     = rx_en_q;
    assign state_o            = state_q;
    assign abort_err          = abort_q;
    assign decode_cnt         = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_owner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_owner_sequencer
//  Description : Directed self-checking bench for sram_owner_sequencer with
//                short timeouts (UART_TMO=64, MS_TMO=128).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_owner_sequencer;

    logic        clk;
    logic        Resetn;
    logic        UART_RX_I;
    logic [17:0] uart_addr, m2_addr, m1_addr, vga_addr;
    logic [15:0] uart_wdata, m2_wdata, m1_wdata;
    logic        uart_we_n, m2_we_n, m1_we_n, m2_stop, m1_stop;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n, UART_rx_initialize, UART_rx_enable, VGA_enable;
    logic        M2_start, M1_start, abort_err;
    logic [2:0]  state_o;
    logic [7:0]  decode_cnt;

    int total = 0;
    int bad   = 0;

    sram_owner_sequencer #(
        .ADDR_W(18), .DATA_W(16), .UART_TMO(64), .MS_TMO(128), .TMR_W(26)
    ) dut (
        .CLOCK_50_I(clk), .Resetn(Resetn), .UART_RX_I(UART_RX_I),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we_n(uart_we_n),
        .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_we_n(m2_we_n), .m2_stop(m2_stop),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_n(m1_we_n), .m1_stop(m1_stop),
        .vga_addr(vga_addr),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .UART_rx_initialize(UART_rx_initialize), .UART_rx_enable(UART_rx_enable),
        .VGA_enable(VGA_enable), .M2_start(M2_start), .M1_start(M1_start),
        .state_o(state_o), .abort_err(abort_err), .decode_cnt(decode_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a start bit and ride through the UART timeout into S_M2
    // (no UART writes, so GAP2 is reached 64 edges after the start edge).
    task automatic run_to_m2();
        UART_RX_I = 1'b0; tick(1); UART_RX_I = 1'b1;
        tick(64);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL gap2_entry: state=%0d expected 2", state_o); end
        tick(1);
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL m2_entry: state=%0d expected 3", state_o); end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; UART_RX_I = 1'b1; vga_addr = '0;
        uart_addr = '0; uart_wdata = '0; uart_we_n = 1'b1;
        m2_addr = '0; m2_wdata = '0; m2_we_n = 1'b1; m2_stop = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_we_n = 1'b1; m1_stop = 1'b0;
        tick(2);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state: state=%0d expected 0", state_o); end
        total++; if (VGA_enable !== 1'b1) begin bad++; $display("FAIL rst_vga: got %b expected 1", VGA_enable); end
        total++; if (SRAM_we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n: got %b expected 1", SRAM_we_n); end
        total++; if ({UART_rx_initialize, UART_rx_enable, M2_start, M1_start, abort_err} !== 5'b0)
            begin bad++; $display("FAIL rst_flags: got %b expected 00000", {UART_rx_initialize, UART_rx_enable, M2_start, M1_start, abort_err}); end
        total++; if (decode_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d expected 0", decode_cnt); end
        total++; if (SRAM_write_data !== 16'd0) begin bad++; $display("FAIL rst_wdata: got %h expected 0", SRAM_write_data); end
        Resetn = 1'b1; vga_addr = 18'h2A5A5;
        tick(100);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL idle_state: state=%0d expected 0", state_o); end
        total++; if (SRAM_address !== 18'h2A5A5) begin bad++; $display("FAIL idle_addr: got %h expected 2a5a5", SRAM_address); end
        total++; if (SRAM_we_n !== 1'b1 || VGA_enable !== 1'b1) begin bad++; $display("FAIL idle_ctrl: we_n=%b vga=%b expected 1 1", SRAM_we_n, VGA_enable); end
    endtask

    task automatic test_uart_rx();
        uart_addr = 18'h00100; uart_wdata = 16'hBEEF;
        UART_RX_I = 1'b0; tick(1); UART_RX_I = 1'b1;
        total++; if (UART_rx_initialize !== 1'b1 || UART_rx_enable !== 1'b0)
            begin bad++; $display("FAIL rx_init: init=%b en=%b expected 1 0", UART_rx_initialize, UART_rx_enable); end
        total++; if (state_o !== 3'd1 || VGA_enable !== 1'b0) begin bad++; $display("FAIL uart_entry: state=%0d vga=%b expected 1 0", state_o, VGA_enable); end
        total++; if (SRAM_address !== 18'h00100 || SRAM_we_n !== 1'b1) begin bad++; $display("FAIL uart_owner: addr=%h we_n=%b expected 00100 1", SRAM_address, SRAM_we_n); end
        tick(1);
        total++; if (UART_rx_initialize !== 1'b0 || UART_rx_enable !== 1'b1)
            begin bad++; $display("FAIL rx_enable: init=%b en=%b expected 0 1", UART_rx_initialize, UART_rx_enable); end
        tick(1);
        total++; if (UART_rx_enable !== 1'b0) begin bad++; $display("FAIL rx_enable_pulse: en=%b expected 0", UART_rx_enable); end
        // A start bit while receiving must be ignored.
        UART_RX_I = 1'b0; tick(1); UART_RX_I = 1'b1;
        total++; if (UART_rx_initialize !== 1'b0 || state_o !== 3'd1) begin bad++; $display("FAIL rx_restart: init=%b state=%0d expected 0 1", UART_rx_initialize, state_o); end
        for (int i = 0; i < 4; i++) begin
            uart_addr = 18'h00100 + 18'(i); uart_wdata = 16'hA000 + 16'(i); uart_we_n = 1'b0;
            #1;
            total++; if (SRAM_we_n !== 1'b0 || SRAM_address !== 18'h00100 + 18'(i) || SRAM_write_data !== 16'hA000 + 16'(i))
                begin bad++; $display("FAIL uart_write%0d: we_n=%b addr=%h data=%h", i, SRAM_we_n, SRAM_address, SRAM_write_data); end
            tick(1); uart_we_n = 1'b1;
            if (i < 3) tick(49);
        end
        // M2 requests a write during the tail; it must not reach the SRAM yet.
        m2_addr = 18'h30000; m2_wdata = 16'hC0DE; m2_we_n = 1'b0;
        tick(63);
        total++; if (state_o !== 3'd1 || SRAM_we_n !== 1'b1) begin bad++; $display("FAIL uart_hold: state=%0d we_n=%b expected 1 1", state_o, SRAM_we_n); end
        tick(1);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL uart_tmo: state=%0d expected 2", state_o); end
    endtask

    task automatic test_gap_m2();
        total++; if (SRAM_we_n !== 1'b1 || SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0 || M2_start !== 1'b0)
            begin bad++; $display("FAIL gap2_mux: we_n=%b addr=%h data=%h m2s=%b expected 1 0 0 0", SRAM_we_n, SRAM_address, SRAM_write_data, M2_start); end
        tick(1);
        total++; if (state_o !== 3'd3 || M2_start !== 1'b1 || SRAM_we_n !== 1'b0 || SRAM_address !== 18'h30000)
            begin bad++; $display("FAIL m2_owner: state=%0d m2s=%b we_n=%b addr=%h expected 3 1 0 30000", state_o, M2_start, SRAM_we_n, SRAM_address); end
        m2_addr = 18'h31234; m2_wdata = 16'h5A5A; #1;
        total++; if (SRAM_address !== 18'h31234 || SRAM_write_data !== 16'h5A5A)
            begin bad++; $display("FAIL m2_track: addr=%h data=%h expected 31234 5a5a", SRAM_address, SRAM_write_data); end
        m2_we_n = 1'b1;
    endtask

    task automatic test_decode();
        m1_stop = 1'b1; tick(1); m1_stop = 1'b0;
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL m1_stop_in_m2: state=%0d expected 3", state_o); end
        tick(98);
        m2_stop = 1'b1; tick(1); m2_stop = 1'b0;
        total++; if (state_o !== 3'd4 || M2_start !== 1'b0 || SRAM_we_n !== 1'b1)
            begin bad++; $display("FAIL gap1: state=%0d m2s=%b we_n=%b expected 4 0 1", state_o, M2_start, SRAM_we_n); end
        m1_addr = 18'h00ABC; m1_wdata = 16'h1111; m1_we_n = 1'b0;
        tick(1);
        total++; if (state_o !== 3'd5 || M1_start !== 1'b1 || SRAM_address !== 18'h00ABC || SRAM_we_n !== 1'b0)
            begin bad++; $display("FAIL m1_owner: state=%0d m1s=%b addr=%h we_n=%b expected 5 1 00abc 0", state_o, M1_start, SRAM_address, SRAM_we_n); end
        m2_stop = 1'b1; tick(1); m2_stop = 1'b0;
        total++; if (state_o !== 3'd5) begin bad++; $display("FAIL m2_stop_in_m1: state=%0d expected 5", state_o); end
        tick(58);
        m1_stop = 1'b1; tick(1); m1_stop = 1'b0; m1_we_n = 1'b1;
        total++; if (state_o !== 3'd0 || decode_cnt !== 8'd1 || VGA_enable !== 1'b1 || M1_start !== 1'b0 || abort_err !== 1'b0)
            begin bad++; $display("FAIL decode_done: state=%0d cnt=%0d vga=%b m1s=%b abort=%b expected 0 1 1 0 0", state_o, decode_cnt, VGA_enable, M1_start, abort_err); end
        total++; if (SRAM_address !== 18'h2A5A5) begin bad++; $display("FAIL vga_return: addr=%h expected 2a5a5", SRAM_address); end
    endtask

    task automatic test_watchdog();
        run_to_m2();
        tick(128);
        total++; if (state_o !== 3'd3 || M2_start !== 1'b1 || abort_err !== 1'b0)
            begin bad++; $display("FAIL wd_pre: state=%0d m2s=%b abort=%b expected 3 1 0", state_o, M2_start, abort_err); end
        tick(1);
        total++; if (state_o !== 3'd0 || abort_err !== 1'b1 || decode_cnt !== 8'd1 || M2_start !== 1'b0)
            begin bad++; $display("FAIL wd_abort: state=%0d abort=%b cnt=%0d m2s=%b expected 0 1 1 0", state_o, abort_err, decode_cnt, M2_start); end
        run_to_m2();
        tick(128);
        m2_stop = 1'b1; tick(1); m2_stop = 1'b0;
        total++; if (state_o !== 3'd4 || abort_err !== 1'b1) begin bad++; $display("FAIL wd_m2_stop_wins: state=%0d abort=%b expected 4 1", state_o, abort_err); end
        tick(1);
        tick(128);
        m1_stop = 1'b1; tick(1); m1_stop = 1'b0;
        total++; if (state_o !== 3'd0 || decode_cnt !== 8'd2) begin bad++; $display("FAIL wd_m1_stop_wins: state=%0d cnt=%0d expected 0 2", state_o, decode_cnt); end
    endtask

    task automatic test_async_reset();
        run_to_m2();
        m2_stop = 1'b1; tick(1); m2_stop = 1'b0; tick(1);
        total++; if (state_o !== 3'd5) begin bad++; $display("FAIL ar_m1: state=%0d expected 5", state_o); end
        m1_we_n = 1'b0; m1_addr = 18'h01234;
        #2 Resetn = 1'b0;
        #1;
        total++; if (state_o !== 3'd0 || M1_start !== 1'b0 || VGA_enable !== 1'b1 || SRAM_we_n !== 1'b1)
            begin bad++; $display("FAIL ar_ctrl: state=%0d m1s=%b vga=%b we_n=%b expected 0 0 1 1", state_o, M1_start, VGA_enable, SRAM_we_n); end
        total++; if (abort_err !== 1'b0 || decode_cnt !== 8'd0 || SRAM_address !== 18'h2A5A5)
            begin bad++; $display("FAIL ar_regs: abort=%b cnt=%0d addr=%h expected 0 0 2a5a5", abort_err, decode_cnt, SRAM_address); end
        m1_we_n = 1'b1;
        tick(1); Resetn = 1'b1; tick(1);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 256; n++) begin
            run_to_m2();
            m2_stop = 1'b1; tick(1); m2_stop = 1'b0; tick(1);
            m1_stop = 1'b1; tick(1); m1_stop = 1'b0;
            if (n == 254) begin
                total++; if (decode_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255: cnt=%0d expected 255", decode_cnt); end
            end
        end
        total++; if (decode_cnt !== 8'd0 || state_o !== 3'd0) begin bad++; $display("FAIL wrap_0: cnt=%0d state=%0d expected 0 0", decode_cnt, state_o); end
    endtask

    initial begin
        test_reset();
        test_uart_rx();
        test_gap_m2();
        test_decode();
        test_watchdog();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
